// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - access-size encodings carried on data_sel_i
//   - responder FSM state enum
//   - helpers: byte-enable generation, misalignment test, store-lane
//     replication and load alignment
// Optional feature macro used by the files that import this package:
//   DMEM_PARITY_EN (per-byte even parity storage and read check)
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 also decodes as word

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2,
    ST_FAULT = 2'd3
  } dmem_state_e;

  // Byte lanes touched by an access of size sel at byte offset off.
  function automatic logic [3:0] byte_en(input logic [1:0] sel, input logic [1:0] off);
    case (sel)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Half must be 2-byte aligned, word (and the 2'b11 alias) 4-byte aligned.
  function automatic logic misaligned(input logic [1:0] sel, input logic [1:0] off);
    case (sel)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  // Store data arrives right-aligned; replicate it across all lanes so the
  // byte enables alone pick the destination bytes.
  function automatic logic [31:0] store_lanes(input logic [31:0] d, input logic [1:0] sel);
    case (sel)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Right-align the addressed byte/half of a word and zero-extend it.
  function automatic logic [31:0] load_align(input logic [31:0] w, input logic [1:0] sel,
                                             input logic [1:0] off);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (sel)
      SZ_BYTE: return {24'd0, sh[7:0]};
      SZ_HALF: return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM, 32-bit words with byte enables.
// Ports:
//   clk   - clock, read and write on the rising edge
//   addr  - word address (ADDR_LSB_W-2 bits)
//   we    - write strobe, lanes selected by be
//   be    - byte enables
//   wdata - write data (already lane-placed)
//   rdata - registered read data of addr (old contents on a write cycle)
//   rpar  - registered per-byte parity bits, only with DMEM_PARITY_EN
// Memory contents are never reset.
module dmem_ram #(
  parameter int ADDR_LSB_W = 12
) (
  input  logic                  clk,
  input  logic [ADDR_LSB_W-3:0] addr,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
`ifdef DMEM_PARITY_EN
  ,
  output logic [3:0]            rpar
`endif
);

  localparam int DEPTH = 1 << (ADDR_LSB_W - 2);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

`ifdef DMEM_PARITY_EN
  // Even parity: stored bit makes the 9-bit group XOR to zero.
  logic [3:0] par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) par_mem[addr][b] <= ^wdata[8*b +: 8];
      end
    end
    rpar <= par_mem[addr];
  end
`endif

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the core's data port.
// A level-held request seen in IDLE is latched, optionally delayed by
// WAIT_CYCLES wait states, then completed with a one-cycle data_valid_o
// (RESP) or rejected with a one-cycle page_fault_o (FAULT).
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   data_addr_i    - byte address
//   data_data_i    - store data, right-aligned
//   data_sel_i     - size: 00 byte, 01 half, 10/11 word
//   data_we_i      - write request (wins when data_rd_i is also high)
//   data_rd_i      - read request
//   data_data_o    - load data, right-aligned, zero-extended; held between strobes
//   data_valid_o   - completion strobe
//   page_fault_o   - fault strobe
//   dbg_state      - current FSM state (dmem_state_e encoding)
// Handshake: a request is the level (data_rd_i | data_we_i). It is sampled
// only in IDLE; dropping it during WAIT aborts silently. After a strobe the
// FSM is back in IDLE for one cycle before it samples the next request, so a
// requester that keeps the level high gets a new access every
// WAIT_CYCLES+2 cycles.
// Optional feature: DMEM_PARITY_EN adds per-byte parity; a read with a
// parity error on any enabled byte faults instead of responding.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_LSB_W  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_data_i,
  input  logic [1:0]  data_sel_i,
  input  logic        data_we_i,
  input  logic        data_rd_i,
  output logic [31:0] data_data_o,
  output logic        data_valid_o,
  output logic        page_fault_o,
  output logic [1:0]  dbg_state
);

  localparam int AW = ADDR_LSB_W - 2;

`ifdef DMEM_PARITY_EN
  // The parity check needs RAM read data, which is only available one cycle
  // after the request is sampled, so a zero-wait build still passes through
  // one WAIT cycle to evaluate it.
  localparam bit DIRECT_RESP = 1'b0;
`else
  localparam bit DIRECT_RESP = (WAIT_CYCLES == 0);
`endif
  localparam logic [3:0] CNT_START = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_e            state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_LSB_W-1:0]  addr_q;
  logic [31:0]            wdata_q;
  logic [1:0]             sel_q;
  logic                   we_q;
  logic [31:0]            load_q;

  logic                   req;
  logic                   out_of_range;
  logic                   req_bad;
  logic                   latch;
  logic [AW-1:0]          ram_addr;
  logic                   ram_we;
  logic [3:0]             be_q;
  logic [31:0]            ram_rdata;
  logic [31:0]            load_val;
  logic                   par_err;

  assign req          = data_rd_i | data_we_i;
  assign out_of_range = (data_addr_i >> ADDR_LSB_W) != 32'd0;
  assign req_bad      = out_of_range | misaligned(data_sel_i, data_addr_i[1:0]);
  assign latch        = (state_q == ST_IDLE) && req;
  assign be_q         = byte_en(sel_q, addr_q[1:0]);

  // In IDLE the RAM reads the live address so data is ready in the first
  // cycle after acceptance; afterwards it follows the latched address.
  assign ram_addr = (state_q == ST_IDLE) ? data_addr_i[ADDR_LSB_W-1:2]
                                         : addr_q[ADDR_LSB_W-1:2];
  assign ram_we   = (state_q == ST_RESP) && we_q;

`ifdef DMEM_PARITY_EN
  logic [3:0] ram_rpar;
  logic [3:0] lane_err;

  dmem_ram #(.ADDR_LSB_W(ADDR_LSB_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (be_q),
    .wdata (store_lanes(wdata_q, sel_q)),
    .rdata (ram_rdata),
    .rpar  (ram_rpar)
  );

  always_comb begin
    lane_err = 4'b0000;
    for (int b = 0; b < 4; b++) lane_err[b] = ^{ram_rdata[8*b +: 8], ram_rpar[b]};
  end
  assign par_err = !we_q && ((lane_err & be_q) != 4'b0000);
`else
  dmem_ram #(.ADDR_LSB_W(ADDR_LSB_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (be_q),
    .wdata (store_lanes(wdata_q, sel_q)),
    .rdata (ram_rdata)
  );
  assign par_err = 1'b0;
`endif

  // A write (alone or combined with a read) returns the old full word.
  assign load_val = we_q ? ram_rdata : load_align(ram_rdata, sel_q, addr_q[1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (req_bad) begin
            state_d = ST_FAULT;
          end else if (DIRECT_RESP) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_START;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;  // request withdrawn: flush
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = par_err ? ST_FAULT : ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      sel_q   <= SZ_BYTE;
      we_q    <= 1'b0;
      load_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        addr_q  <= data_addr_i[ADDR_LSB_W-1:0];
        wdata_q <= data_data_i;
        sel_q   <= data_sel_i;
        we_q    <= data_we_i;
      end
      if (state_q == ST_RESP) load_q <= load_val;
    end
  end

  assign data_valid_o = (state_q == ST_RESP);
  assign page_fault_o = (state_q == ST_FAULT);
  // Live value during the strobe, then held until the next one.
  assign data_data_o  = (state_q == ST_RESP) ? load_val : load_q;
  assign dbg_state    = state_q;

endmodule
